// File: rtl/e_3_pkg.sv
// Shared constants, state encoding and Gray helper for the e_3 up/down Gray counter.
package e_3_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] STATE_RST = 3'b000;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Binary count states; encoding equals the binary count value.
    typedef enum logic [STATE_W-1:0] {
        ST_0 = 3'd0,
        ST_1 = 3'd1,
        ST_2 = 3'd2,
        ST_3 = 3'd3,
        ST_4 = 3'd4,
        ST_5 = 3'd5,
        ST_6 = 3'd6,
        ST_7 = 3'd7
    } state_e;

    // Reflected binary Gray code of a binary count.
    function automatic logic [STATE_W-1:0] bin2gray(input logic [STATE_W-1:0] s);
        return s ^ (s >> 1);
    endfunction

endpackage

// File: rtl/e_3_gray_enc.sv
// Combinational 3-bit binary-to-Gray encoder.
module e_3_gray_enc
    import e_3_pkg::*;
(
    input  logic [STATE_W-1:0] i_bin,
    output logic [STATE_W-1:0] o_gray
);

    assign o_gray = bin2gray(i_bin);

endmodule

// File: rtl/e_3.sv
// 3-bit up/down counter Moore FSM with Gray-coded output and bit-level port breakout.
module e_3
    import e_3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic A,
    output logic S2,
    output logic S1,
    output logic S0,
    output logic SF2,
    output logic SF1,
    output logic SF0,
    output logic Y2,
    output logic Y1,
    output logic Y0
);

    state_e               r_state;
    state_e               w_next;
    logic [STATE_W-1:0]   w_cur;
    logic [STATE_W-1:0]   w_gray;

    assign w_cur = r_state;

    // State register: synchronous reset wins over the direction input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= state_e'(STATE_RST);
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: mod-8 increment or decrement; evaluated regardless of reset.
    always_comb begin
        w_next = r_state;
        if (A == DIR_UP) begin
            w_next = state_e'(w_cur + STATE_W'(1));
        end else begin
            w_next = state_e'(w_cur - STATE_W'(1));
        end
    end

    e_3_gray_enc u_gray_enc (
        .i_bin  (w_cur),
        .o_gray (w_gray)
    );

    assign {S2, S1, S0}    = w_cur;
    assign {SF2, SF1, SF0} = w_next;
    assign {Y2, Y1, Y0}    = w_gray;

endmodule

// File: tb/tb_e_3.sv
// Directed scoreboard bench for the e_3 up/down Gray counter.
module tb_e_3;

    logic clk;
    logic rst;
    logic A;
    logic S2, S1, S0;
    logic SF2, SF1, SF0;
    logic Y2, Y1, Y0;

    typedef struct {
        logic [2:0] s;
        logic [2:0] y;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         n_tests;
    int         n_fail;
    int         m_s;
    bit         m_valid;
    logic [2:0] gray_tbl [8];

    e_3 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .S2  (S2),
        .S1  (S1),
        .S0  (S0),
        .SF2 (SF2),
        .SF1 (SF1),
        .SF0 (SF0),
        .Y2  (Y2),
        .Y1  (Y1),
        .Y0  (Y0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check combinational next state and held state,
    // push the post-edge expectation, then pop and compare after the edge.
    task automatic step(input logic r, input logic a, input string tag);
        exp_t       e;
        exp_t       got;
        int         nxt;
        int         new_s;
        logic [2:0] obs_y;
        rst = r;
        A   = a;
        #1;
        nxt = 0;
        if (m_valid) begin
            nxt = a ? (m_s + 1) % 8 : (m_s + 7) % 8;
            check({tag, "/SF"}, {SF2, SF1, SF0}, 3'(nxt));
            check({tag, "/S_hold"}, {S2, S1, S0}, 3'(m_s));
        end
        new_s = r ? 0 : nxt;
        e.s   = 3'(new_s);
        e.y   = gray_tbl[new_s];
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s/sb_empty: observed 0 entries expected 1", tag);
        end else begin
            got   = sb.pop_front();
            obs_y = {Y2, Y1, Y0};
            check({got.tag, "/S"}, {S2, S1, S0}, got.s);
            check({got.tag, "/Y"}, obs_y, got.y);
            if (!r && m_valid) begin
                n_tests++;
                assert ($countones(obs_y ^ gray_tbl[m_s]) == 1) else begin
                    n_fail++;
                    $error("FAIL %s/gray1: observed %0d bit changes expected 1",
                           got.tag, $countones(obs_y ^ gray_tbl[m_s]));
                end
            end
        end
        m_s     = new_s;
        m_valid = 1'b1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        m_s      = 0;
        m_valid  = 1'b0;
        gray_tbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        rst = 1'b1;
        A   = 1'b0;

        // Reset with A=0, then one down edge wraps to 111.
        step(1'b1, 1'b0, "rst_dn");
        step(1'b0, 1'b0, "dn_wrap0");

        // Reset pulse, then a full up lap including 111 -> 000.
        step(1'b1, 1'b1, "rst_up");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, $sformatf("up%0d", i));

        // Up to 101, then reverse: 100, 011, 010.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $sformatf("to5_%0d", i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $sformatf("rev%0d", i));

        // Wrap checks from 010: climb to 111, wrap up, then wrap down.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $sformatf("to7_%0d", i));
        step(1'b0, 1'b1, "wrap_up");
        step(1'b0, 1'b0, "wrap_dn");

        // Reach 110, then assert reset mid-count while counting up.
        step(1'b0, 1'b0, "to6");
        step(1'b1, 1'b1, "rst_mid");

        // Reset held three edges with A toggling.
        step(1'b1, 1'b0, "rst_hold0");
        step(1'b1, 1'b1, "rst_hold1");
        step(1'b1, 1'b0, "rst_hold2");

        // Resume counting from 000.
        step(1'b0, 1'b1, "resume");
        step(1'b0, 1'b1, "resume2");

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/e_3.md
Name: e_3

Overview:
- 3-bit up/down Gray-code counter built as a Moore FSM with one direction input A.
- The state register holds a binary count 0..7.
- Exposes the current state, the combinational next state and the Gray-coded output as individual bits.
- Lab-level block, driven directly by a testbench clock; no upstream/downstream handshake.

Parameters:
- none (width fixed at 3 bits; ports are scalar bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- A  input  1  direction: 1 = count up, 0 = count down
- S2  output  1  current state bit 2 (MSB, binary)
- S1  output  1  current state bit 1
- S0  output  1  current state bit 0 (LSB)
- SF2  output  1  next-state bit 2 (combinational)
- SF1  output  1  next-state bit 1
- SF0  output  1  next-state bit 0
- Y2  output  1  Gray output bit 2 (MSB)
- Y1  output  1  Gray output bit 1
- Y0  output  1  Gray output bit 0

Behaviour:
- State S = {S2,S1,S0}, 3-bit binary register, updated only on the rising edge of clk.
- Reset is synchronous and active-high: rst=1 at a rising edge loads S=000. This overrides A and is independent of the current state.
- With rst=0 at a rising edge, S loads SF.
- Next state SF = {SF2,SF1,SF0}, purely combinational from S and A:
  - A=1: SF = (S+1) mod 8, so 111 wraps to 000.
  - A=0: SF = (S-1) mod 8, so 000 wraps to 111.
- Output Y = {Y2,Y1,Y0} is Moore, depending on S only: Y2=S2, Y1=S2^S1, Y0=S1^S0.
- Up sequence of Y: 000,001,011,010,110,111,101,100, then back to 000. Down is the reverse order.
- After reset: S=000, Y=000, SF=001 if A=1, SF=111 if A=0.
- SF follows A and S even while rst=1; only the register is forced by reset.
- A changing mid-cycle: takes effect at the next rising edge. No glitch filtering; A is assumed synchronous to clk.
- Reset mid-count: next edge with rst=1 yields S=000 regardless of direction. Counting resumes from 000 on the first edge with rst=0.
- Power-up before the first reset: S undefined; the bench must apply rst.
- Exactly one Y bit changes per clock edge in normal counting (Gray property). Wrap-around edges are included.

Decomposition:
- Shared package holds:
  - STATE_W = 3
  - STATE_RST = 3'b000
  - a function bin2gray(s) = s ^ (s >> 1)
  - direction constants DIR_UP = 1'b1, DIR_DN = 1'b0
- One natural sub-module: e_3_gray_enc, a combinational 3-bit binary-to-Gray encoder producing Y from S.
- Top e_3 contains the state register, the next-state logic (up/down mod-8) and the bit-level port breakout.

Test Plan:
- rst=1 for one edge, A=0 -> S=000, Y=000, SF=111. Release rst, A=0, one edge -> S=111, Y=100.
- rst pulse, then A=1 for 8 edges -> S steps 001..111,000. Y steps 001,011,010,110,111,101,100,000. Exactly one Y bit toggles per edge.
- Up-count to S=101, then A=0 -> SF immediately 100. Subsequent edges give S=100,011,010, Y=110,010,011.
- Wrap checks:
  - S=111, A=1, one edge -> S=000.
  - S=000, A=0, one edge -> S=111.
- Reset mid-count: at S=110 (A=1), assert rst between edges -> S holds 110 until the next rising edge, then 000. Y=000; SF=001 while rst is high.
- Reset priority: rst=1 held for 3 edges with A toggling -> S stays 000 throughout. SF alternates 001/111 following A.
